// File: rtl/instr_fetch.sv
// instr_fetch: program counter, instruction-memory request issue, response
// buffering and branch-redirect handling for the fetch stage.
// Requests are credit limited: outstanding requests plus buffered words
// never exceed DEPTH, so every returning word always has a FIFO slot.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_target
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ZERO = AW'(0);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [31:0]   NOP      = 32'h0000_0013;

   logic [31:0]   r_pc;
   logic [AW:0]   r_out_cnt;
   logic [AW:0]   r_disc_cnt;
   logic [AW:0]   r_fifo_cnt;
   logic [AW-1:0] r_fifo_wr;
   logic [AW-1:0] r_fifo_rd;
   logic [AW-1:0] r_aq_wr;
   logic [AW-1:0] r_aq_rd;
   logic [31:0]   r_fifo_data [DEPTH];
   logic [31:0]   r_fifo_pc   [DEPTH];
   logic [31:0]   r_aq_addr   [DEPTH];

   logic [AW+1:0] w_used;
   logic          w_req_valid;
   logic          w_req_fire;
   logic          w_rsp_take;
   logic          w_rsp_drop;
   logic          w_push;
   logic          w_fifo_nonempty;
   logic          w_pop;
   logic [31:0]   w_target;
   logic [31:0]   w_pc_nxt;
   logic [AW:0]   w_out_nxt;
   logic [AW:0]   w_disc_nxt;
   logic [AW:0]   w_fifo_cnt_nxt;
   logic [AW-1:0] w_fifo_wr_nxt;
   logic [AW-1:0] w_fifo_rd_nxt;
   logic [AW-1:0] w_aq_wr_nxt;
   logic [AW-1:0] w_aq_rd_nxt;

   // Handshake qualification and next-state computation for all counters and pointers.
   always_comb begin
      w_used          = {1'b0, r_out_cnt} + {1'b0, r_fifo_cnt};
      w_req_valid     = rst_n & (w_used < {1'b0, CNT_MAX});
      w_req_fire      = w_req_valid & imem_req_ready;
      // A response with nothing outstanding is a protocol error and is ignored.
      w_rsp_take      = imem_rsp_valid & (r_out_cnt != CNT_ZERO);
      w_rsp_drop      = w_rsp_take & ((r_disc_cnt != CNT_ZERO) | redirect);
      w_push          = w_rsp_take & ~w_rsp_drop;
      w_fifo_nonempty = (r_fifo_cnt != CNT_ZERO);
      w_pop           = w_fifo_nonempty & instr_ready;
      w_target        = redirect_target & 32'hFFFF_FFFC;

      w_out_nxt      = r_out_cnt + (w_req_fire ? CNT_ONE : CNT_ZERO)
                                 - (w_rsp_take ? CNT_ONE : CNT_ZERO);
      w_aq_wr_nxt    = r_aq_wr + (w_req_fire ? PTR_ONE : PTR_ZERO);
      w_aq_rd_nxt    = r_aq_rd + (w_rsp_take ? PTR_ONE : PTR_ZERO);
      w_pc_nxt       = r_pc;
      w_disc_nxt     = r_disc_cnt;
      w_fifo_cnt_nxt = r_fifo_cnt;
      w_fifo_wr_nxt  = r_fifo_wr;
      w_fifo_rd_nxt  = r_fifo_rd;

      if (redirect) begin
         // Everything still in flight after this edge belongs to the old path.
         w_pc_nxt       = w_target;
         w_disc_nxt     = w_out_nxt;
         w_fifo_cnt_nxt = CNT_ZERO;
         w_fifo_wr_nxt  = PTR_ZERO;
         w_fifo_rd_nxt  = PTR_ZERO;
      end else begin
         w_pc_nxt       = w_req_fire ? (r_pc + 32'd4) : r_pc;
         w_disc_nxt     = (w_rsp_take && (r_disc_cnt != CNT_ZERO)) ? (r_disc_cnt - CNT_ONE) : r_disc_cnt;
         w_fifo_cnt_nxt = r_fifo_cnt + (w_push ? CNT_ONE : CNT_ZERO) - (w_pop ? CNT_ONE : CNT_ZERO);
         w_fifo_wr_nxt  = r_fifo_wr + (w_push ? PTR_ONE : PTR_ZERO);
         w_fifo_rd_nxt  = r_fifo_rd + (w_pop ? PTR_ONE : PTR_ZERO);
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_out_cnt  <= CNT_ZERO;
         r_disc_cnt <= CNT_ZERO;
         r_fifo_cnt <= CNT_ZERO;
         r_fifo_wr  <= PTR_ZERO;
         r_fifo_rd  <= PTR_ZERO;
         r_aq_wr    <= PTR_ZERO;
         r_aq_rd    <= PTR_ZERO;
      end else begin
         r_pc       <= w_pc_nxt;
         r_out_cnt  <= w_out_nxt;
         r_disc_cnt <= w_disc_nxt;
         r_fifo_cnt <= w_fifo_cnt_nxt;
         r_fifo_wr  <= w_fifo_wr_nxt;
         r_fifo_rd  <= w_fifo_rd_nxt;
         r_aq_wr    <= w_aq_wr_nxt;
         r_aq_rd    <= w_aq_rd_nxt;
      end
   end

   // Data storage: address queue written on request handshake, FIFO on kept response.
   always_ff @(posedge clk) begin
      if (w_req_fire) begin
         r_aq_addr[r_aq_wr] <= r_pc;
      end
      if (w_push) begin
         r_fifo_data[r_fifo_wr] <= imem_rsp_data;
         r_fifo_pc[r_fifo_wr]   <= r_aq_addr[r_aq_rd];
      end
   end

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_pc;
   assign instr_valid    = rst_n & w_fifo_nonempty;
   assign instr          = instr_valid ? r_fifo_data[r_fifo_rd] : NOP;
   assign instr_pc       = instr_valid ? r_fifo_pc[r_fifo_rd] : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios followed by randomized traffic against a
// transaction-level model (memory queue, expected request PC, expected delivered PC).
`timescale 1ns/1ps
module tb_instr_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_target;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redirect(redirect), .redirect_target(redirect_target)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mem_q[$];
   int          cyc, last_due, lat, n_cmp, n_err, n_hs, n_del;
   logic [31:0] mem_xor, m_req_pc, m_exp_pc;
   logic        m_redir_prev;
   logic        s_req_valid, s_ivalid;
   logic [31:0] s_req_addr, s_instr, s_ipc;

   function automatic logic [31:0] b2w(input logic b);
      return {31'b0, b};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      mem_q.delete();
      last_due     = 0;
      cyc          = 0;
      m_req_pc     = RESET_PC;
      m_exp_pc     = RESET_PC;
      m_redir_prev = 1'b0;
   endtask

   // One clock cycle: present memory response, sample, check against model, advance.
   task automatic cycle();
      mreq_t r;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0000_0000;
      if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         r = mem_q.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = r.addr ^ mem_xor;
      end
      #1;
      s_req_valid = imem_req_valid;
      s_req_addr  = imem_req_addr;
      s_ivalid    = instr_valid;
      s_instr     = instr;
      s_ipc       = instr_pc;
      if (!rst_n) begin
         chk("rst_req_valid", b2w(s_req_valid), 32'd0);
         chk("rst_instr_valid", b2w(s_ivalid), 32'd0);
         chk("rst_instr", s_instr, 32'h0000_0013);
         chk("rst_instr_pc", s_ipc, 32'h0000_0000);
      end else begin
         if (s_req_valid) chk("req_addr", s_req_addr, m_req_pc);
         if (m_redir_prev) chk("post_redirect_valid", b2w(s_ivalid), 32'd0);
         if (s_ivalid) begin
            chk("instr_pc", s_ipc, m_exp_pc);
            chk("instr_data", s_instr, s_ipc ^ mem_xor);
            if (instr_ready) begin
               m_exp_pc = m_exp_pc + 32'd4;
               n_del++;
            end
         end else begin
            chk("idle_instr", s_instr, 32'h0000_0013);
            chk("idle_pc", s_ipc, 32'h0000_0000);
         end
         if (s_req_valid && imem_req_ready) begin
            r.addr   = s_req_addr;
            r.due    = (cyc + lat > last_due + 1) ? (cyc + lat) : (last_due + 1);
            last_due = r.due;
            mem_q.push_back(r);
            m_req_pc = m_req_pc + 32'd4;
            n_hs++;
         end
         chk("outstanding_bound", (mem_q.size() <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
         m_redir_prev = redirect;
         if (redirect) begin
            m_req_pc = {redirect_target[31:2], 2'b00};
            m_exp_pc = {redirect_target[31:2], 2'b00};
         end
      end
      @(posedge clk);
      if (!rst_n) model_reset();
      else cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      redirect = 1'b0;
      rst_n    = 1'b0;
      cycle();
      rst_n    = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          hs0, k;
      logic [31:0] exp_wrap [3];
      rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      instr_ready = 1'b1; redirect = 1'b0; redirect_target = 32'h0;
      n_cmp = 0; n_err = 0; n_hs = 0; n_del = 0; lat = 1; mem_xor = 32'h0;
      model_reset();

      // Reset, then streaming with 1-cycle memory returning address as data.
      repeat (2) cycle();
      rst_n = 1'b1;
      cycle();
      chk("t1_first_req_valid", b2w(s_req_valid), 32'd1);
      chk("t1_first_req_addr", s_req_addr, RESET_PC);
      cycle();
      chk("t1_c1_valid", b2w(s_ivalid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("t1_stream_valid", b2w(s_ivalid), 32'd1);
         chk("t1_stream_pc", s_ipc, RESET_PC + 32'(4 * i));
         chk("t1_stream_instr", s_instr, RESET_PC + 32'(4 * i));
      end

      // Decoder stalled: credits stop requests at DEPTH, then drain in order.
      do_reset();
      instr_ready = 1'b0;
      hs0 = n_hs;
      repeat (10) cycle();
      chk("t2_req_count", 32'(n_hs - hs0), 32'd4);
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("t2_drain_valid", b2w(s_ivalid), 32'd1);
         chk("t2_drain_pc", s_ipc, 32'(4 * i));
         if (i == 1) begin
            chk("t2_resume_valid", b2w(s_req_valid), 32'd1);
            chk("t2_resume_addr", s_req_addr, 32'h0000_0010);
         end
      end

      // Latency 3, redirect with three requests in flight.
      do_reset();
      lat = 3;
      cycle();
      cycle();
      redirect = 1'b1; redirect_target = 32'h0000_0100;
      cycle();
      redirect = 1'b0;
      chk("t3_outstanding", 32'(mem_q.size()), 32'd3);
      k = 0;
      while (k < 20) begin
         cycle();
         k++;
         if (s_ivalid) break;
      end
      chk("t3_target_seen", b2w(s_ivalid), 32'd1);
      chk("t3_target_pc", s_ipc, 32'h0000_0100);
      chk("t3_wait_cycles", 32'(k), 32'd5);

      // Redirect in the same cycle as a response and a request handshake.
      do_reset();
      lat = 1;
      cycle();
      redirect = 1'b1; redirect_target = 32'h0000_0200;
      cycle();
      redirect = 1'b0;
      chk("t4_hs_in_redirect", b2w(s_req_valid), 32'd1);
      cycle();
      chk("t4_n1_valid", b2w(s_ivalid), 32'd0);
      chk("t4_n1_req_addr", s_req_addr, 32'h0000_0200);
      k = 0;
      while (k < 20) begin
         cycle();
         k++;
         if (s_ivalid) break;
      end
      chk("t4_target_pc", s_ipc, 32'h0000_0200);
      chk("t4_wait_cycles", 32'(k), 32'd2);

      // PC wrap through the top of the address space (low target bits ignored).
      exp_wrap[0] = 32'hFFFF_FFF8; exp_wrap[1] = 32'hFFFF_FFFC; exp_wrap[2] = 32'h0000_0000;
      redirect = 1'b1; redirect_target = 32'hFFFF_FFFA;
      cycle();
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t5_wrap_valid", b2w(s_req_valid), 32'd1);
         chk("t5_wrap_addr", s_req_addr, exp_wrap[i]);
      end
      repeat (4) cycle();

      // Reset pulse with a full buffer.
      instr_ready = 1'b0;
      repeat (8) cycle();
      chk("t6_full_valid", b2w(s_ivalid), 32'd1);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      instr_ready = 1'b1;
      cycle();
      chk("t6_after_valid", b2w(s_ivalid), 32'd0);
      chk("t6_after_instr", s_instr, 32'h0000_0013);
      chk("t6_after_pc", s_ipc, 32'h0000_0000);
      chk("t6_restart_valid", b2w(s_req_valid), 32'd1);
      chk("t6_restart_addr", s_req_addr, RESET_PC);

      // Randomized traffic: ready stalls, varying latency, frequent redirects.
      mem_xor = $urandom;
      do_reset();
      n_del = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) lat = $urandom_range(1, 4);
         imem_req_ready  = ($urandom_range(0, 3) != 0);
         instr_ready     = ($urandom_range(0, 9) < 7);
         redirect        = ($urandom_range(0, 19) == 0);
         redirect_target = $urandom;
         cycle();
      end
      redirect = 1'b0;
      chk("rand_progress", (n_del > 100) ? 32'd1 : 32'd0, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the RISC-V core. Holds the program counter and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel. Buffers returned words in a small FIFO and presents them, with their PC, to the decode/control unit. Applies branch redirects (PCsrc plus target) by flushing the buffer and discarding stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- DEPTH, 4, instruction buffer entries and maximum outstanding requests (power of two, ≥2)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- imem_req_valid  out  1  request valid
- imem_req_addr  out  32  word-aligned fetch address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response word valid (in order, ≥1 cycle after acceptance, ≤1 per cycle)
- imem_rsp_data  in  32  instruction word
- instr  out  32  instruction to decoder
- instr_pc  out  32  address of instr
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  decoder consumes instr
- redirect  in  1  taken branch (PCsrc), redirect fetch this cycle
- redirect_target  in  32  new PC; bits [1:0] ignored (treated as 0)

## Operation
- State: pc, outstanding count, discard count, FIFO (data + pc per entry), address queue of outstanding requests (DEPTH entries).
- Request: imem_req_valid = 1 when rst_n high and (outstanding + fifo_count) < DEPTH, using registered counts only; imem_req_addr = pc. Handshake when valid & ready: push pc into address queue, outstanding+1, pc <= pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
- Response: on imem_rsp_valid, pop address queue, outstanding-1. If discard count > 0 or redirect high this cycle, drop word and decrement discard (if > 0); else push {data, addr} into FIFO.
- Output: instr_valid = FIFO non-empty; instr/instr_pc = FIFO head. When empty, instr = 32'h0000_0013 (addi x0,x0,0) and instr_pc = 0. Pop on instr_valid & instr_ready.
- Redirect (highest priority): pc <= {redirect_target[31:2],2'b00}; FIFO cleared (same-cycle pop is harmless); discard <= outstanding count after this cycle's request/response updates, so every request accepted up to and including the redirect cycle is dropped. A request accepted in the redirect cycle uses the old pc and is discarded.
- Simultaneous push and pop with full FIFO impossible by credit rule; simultaneous push/pop at any other level keeps count.
- Response with outstanding = 0 is a protocol error; ignored (no state change).

## Timing
- Reset (rst_n low at edge): pc = RESET_PC, all counts 0, FIFO empty. While rst_n low: imem_req_valid = 0, instr_valid = 0, instr = 32'h0000_0013, instr_pc = 0.
- First request, addr RESET_PC, in first cycle with rst_n high.
- Response arriving cycle N: instr_valid at cycle N+1 (no bypass). Memory latency 1 -> first instr_valid 2 cycles after first request.
- Throughput: one instruction per cycle with 1-cycle memory latency, DEPTH = 4, constant instr_ready and imem_req_ready.
- Redirect at cycle N: instr_valid = 0 at N+1; request to target at N+1 (if credit); first target instruction visible ≥2 cycles later, after all stale responses drained.
- Reset mid-operation clears everything at that edge; responses to pre-reset requests arriving after reset are ignored as protocol errors.

## Test plan
- Reset, RESET_PC = 0, 1-cycle memory returning addr as data -> requests 0,4,8...; instr_valid first at cycle 2 with instr_pc=0, then one per cycle with instr = instr_pc.
- instr_ready held low 10 cycles -> exactly 4 requests total (DEPTH), FIFO holds 0,4,8,C; releasing ready drains in order and requests resume at 0x10.
- Memory latency 3, redirect to 0x100 with 3 outstanding -> all 3 responses dropped, instr_valid low until word for 0x100 appears with instr_pc = 0x100.
- Redirect in same cycle as a response and a request handshake -> both dropped, next delivered instr_pc = target.
- pc = 32'hFFFF_FFF8 via redirect -> requests FFFF_FFF8, FFFF_FFFC, 0000_0000 in sequence.
- rst_n pulsed low mid-stream with full FIFO -> next cycle instr_valid = 0, instr = 32'h13; fetch restarts at RESET_PC.
